// File: rtl/op_reg_bank_if.sv
// rtl/op_reg_bank_if.sv - host write/read bus and status lines of the operand register bank
interface op_reg_bank_if #(
  parameter int DATA_W = 32
);
  logic                  write_en;
  logic [31:0]           write_addr;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W/8-1:0]   write_strb;
  logic [31:0]           read_addr;
  logic [DATA_W-1:0]     read_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output write_en, write_addr, write_data, write_strb, read_addr,
    input  read_data, busy, done, err
  );

  modport slave (
    input  write_en, write_addr, write_data, write_strb, read_addr,
    output read_data, busy, done, err
  );
endinterface

// File: rtl/op_reg_bank.sv
// rtl/op_reg_bank.sv - register bank with a small ALU/memory-op sequencer; OP_REG_BANK_MUL_EN adds shift-add MUL
module op_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic         clk,
  input  logic         reset,
  op_reg_bank_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB    = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [IDX_W-1:0] R_OPA  = IDX_W'(0);
  localparam logic [IDX_W-1:0] R_OPB  = IDX_W'(1);
  localparam logic [IDX_W-1:0] R_CTRL = IDX_W'(2);
  localparam logic [IDX_W-1:0] R_RES  = IDX_W'(3);
  localparam logic [IDX_W-1:0] R_SEL  = IDX_W'(4);
  localparam logic [IDX_W-1:0] R_STAT = IDX_W'(5);
  localparam logic [IDX_W-1:0] R_MEM0 = IDX_W'(6);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_MPL = 4'd6;
  localparam logic [3:0] OP_MMI = 4'd7;
  localparam logic [3:0] OP_MR  = 4'd8;
  localparam logic [3:0] OP_MC  = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [IDX_W-1:0]  sel_q;
  logic [DATA_W-1:0] snap_a, snap_b, snap_m, snap_r;
  logic              done_q, done_sticky, err_q;
  logic [15:0]       op_count;

  logic [IDX_W-1:0]  wr_idx, rd_idx, sel_now;
  logic [DATA_W-1:0] wmask, wmerged, wkeep;
  logic [63:0]       wd_ext, status_word;
  logic              start_req, accept, reject, exec_done;
  logic              wb_en, op_bad, wb_fire, host_ok, mem_bad;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_val;

  assign wr_idx  = bus.write_addr[IDX_W+1:2];
  assign rd_idx  = bus.read_addr[IDX_W+1:2];
  assign sel_now = regs[R_SEL][IDX_W-1:0];

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{bus.write_strb[i]}};
  end

  assign wmerged = (regs[wr_idx] & ~wmask) | (bus.write_data & wmask);
  assign wd_ext  = 64'(bus.write_data & wmask);

  // CTRL keeps only the opcode (start reads back 0); MEM_SEL keeps only the index
  always_comb begin
    case (wr_idx)
      R_CTRL:  wkeep = DATA_W'(4'hF);
      R_SEL:   wkeep = DATA_W'({IDX_W{1'b1}});
      default: wkeep = '1;
    endcase
  end

  assign start_req = bus.write_en && (wr_idx == R_CTRL) && wd_ext[4];
  assign accept    = start_req && (state == ST_IDLE);
  assign reject    = start_req && (state != ST_IDLE);
  assign mem_bad   = sel_q < R_MEM0;

`ifdef OP_REG_BANK_MUL_EN
  localparam int CNT_W = $clog2(DATA_W) + 1;
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] mul_a, mul_b, mul_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
    end else if (accept) begin
      mul_cnt <= '0;
      mul_a   <= regs[R_OPA];
      mul_b   <= regs[R_OPB];
      mul_acc <= '0;
    end else if (state == ST_EXEC && op_q == OP_MUL) begin
      mul_cnt <= mul_cnt + 1'b1;
      if (mul_b[0]) mul_acc <= mul_acc + mul_a;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
    end
  end

  assign exec_done = (op_q != OP_MUL) || (mul_cnt == CNT_W'(DATA_W - 1));
`else
  assign exec_done = 1'b1;
`endif

  always_comb begin
    wb_en  = 1'b0;
    op_bad = 1'b0;
    wb_idx = R_RES;
    wb_val = '0;
    case (op_q)
      OP_ADD: begin wb_en = 1'b1; wb_val = snap_a + snap_b; end
      OP_SUB: begin wb_en = 1'b1; wb_val = snap_a - snap_b; end
      OP_AND: begin wb_en = 1'b1; wb_val = snap_a & snap_b; end
      OP_OR:  begin wb_en = 1'b1; wb_val = snap_a | snap_b; end
      OP_XOR: begin wb_en = 1'b1; wb_val = snap_a ^ snap_b; end
      OP_LDA: begin wb_en = !mem_bad; op_bad = mem_bad; wb_idx = R_OPA; wb_val = snap_m; end
      OP_MPL: begin wb_en = !mem_bad; op_bad = mem_bad; wb_idx = sel_q; wb_val = snap_m + snap_r; end
      OP_MMI: begin wb_en = !mem_bad; op_bad = mem_bad; wb_idx = sel_q; wb_val = snap_m - snap_r; end
      OP_MR:  begin wb_en = !mem_bad; op_bad = mem_bad; wb_val = snap_m; end
      OP_MC:  begin wb_en = !mem_bad; op_bad = mem_bad; wb_idx = sel_q; end
`ifdef OP_REG_BANK_MUL_EN
      OP_MUL: begin wb_en = 1'b1; wb_val = mul_acc; end
`endif
      default: op_bad = 1'b1;
    endcase
  end

  // writeback owns its target register for that edge; a colliding host write is dropped
  assign wb_fire = (state == ST_WB) && wb_en;
  assign host_ok = bus.write_en && (wr_idx != R_RES) && (wr_idx != R_STAT)
                   && !(wb_fire && (wr_idx == wb_idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      state       <= ST_IDLE;
      op_q        <= '0;
      sel_q       <= '0;
      snap_a      <= '0;
      snap_b      <= '0;
      snap_m      <= '0;
      snap_r      <= '0;
      done_q      <= 1'b0;
      done_sticky <= 1'b0;
      err_q       <= 1'b0;
      op_count    <= '0;
    end else begin
      done_q <= 1'b0;
      if (host_ok) regs[wr_idx] <= wmerged & wkeep;
      if (bus.write_en && wr_idx == R_STAT) begin
        if (wd_ext[30]) done_sticky <= 1'b0;
        if (wd_ext[29]) err_q <= 1'b0;
      end
      if (reject) err_q <= 1'b1;
      case (state)
        ST_IDLE: if (accept) begin
          state  <= ST_EXEC;
          op_q   <= wd_ext[3:0];
          sel_q  <= sel_now;
          snap_a <= regs[R_OPA];
          snap_b <= regs[R_OPB];
          snap_m <= regs[sel_now];
          snap_r <= regs[R_RES];
        end
        ST_EXEC: if (exec_done) state <= ST_WB;
        ST_WB: begin
          state       <= ST_IDLE;
          done_q      <= 1'b1;
          done_sticky <= 1'b1;
          op_count    <= op_count + 16'd1;
          if (op_bad) err_q <= 1'b1;
          if (wb_en) regs[wb_idx] <= wb_val;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign status_word = {32'b0, bus.busy, done_sticky, err_q, 13'b0, op_count};

  always_comb begin
    if (rd_idx == R_STAT) bus.read_data = status_word[DATA_W-1:0];
    else                  bus.read_data = regs[rd_idx];
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.err  = err_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.write_addr[31:IDX_W+2], bus.write_addr[1:0],
                         bus.read_addr[31:IDX_W+2], bus.read_addr[1:0], wd_ext, status_word};
endmodule

// File: tb/tb_op_reg_bank.sv
// tb/tb_op_reg_bank.sv - directed checks of op_reg_bank (32-bit, 16 registers)
module tb_op_reg_bank;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [31:0] rv;
  logic seen;

  op_reg_bank_if #(.DATA_W(32)) bus ();

  op_reg_bank #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wrs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.write_en   = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
    bus.write_strb = s;
    step();
    bus.write_en   = 1'b0;
    bus.write_strb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wrs(a, d, 4'hF);
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.read_addr = a;
    #1;
    check(tag, bus.read_data, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.write_en   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.write_strb = '0;
    bus.read_addr  = '0;
    step();
    step();
    reset = 1'b0;

    // reset state
    for (int i = 0; i < 16; i++) chk_reg($sformatf("reset_r%0d", i), 32'(i * 4), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_err",  32'(bus.err),  32'h0);

    // SUB wraps modulo 2^32
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h04, 32'h2);
    wr(32'h08, 32'h11);
    check("sub_busy0", 32'(bus.busy), 32'h1);
    check("sub_done0", 32'(bus.done), 32'h0);
    step();
    check("sub_busy1", 32'(bus.busy), 32'h1);
    check("sub_done1", 32'(bus.done), 32'h0);
    step();
    check("sub_done2", 32'(bus.done), 32'h1);
    check("sub_busy2", 32'(bus.busy), 32'h0);
    chk_reg("sub_result", 32'h0C, 32'hFFFF_FFFD);
    step();
    check("sub_done3", 32'(bus.done), 32'h0);
    chk_reg("sub_status", 32'h14, 32'h4000_0001);
    chk_reg("ctrl_start_reads0", 32'h08, 32'h1);

    // RESULT = 5 via ADD
    wr(32'h00, 32'h2);
    wr(32'h04, 32'h3);
    wr(32'h08, 32'h10);
    step();
    step();
    chk_reg("add_result", 32'h0C, 32'h5);

    // M_PLUS with a colliding host write at the WB edge
    wr(32'h10, 32'h7);
    wr(32'h1C, 32'h10);
    wr(32'h08, 32'h16);
    step();
    wr(32'h1C, 32'h99);
    check("mplus_done", 32'(bus.done), 32'h1);
    chk_reg("mplus_mem7", 32'h1C, 32'h15);
    chk_reg("mplus_result_kept", 32'h0C, 32'h5);

    // second start while busy is rejected
    wr(32'h00, 32'h6);
    wr(32'h08, 32'h10);
    wr(32'h08, 32'h13);
    check("rej_err", 32'(bus.err), 32'h1);
    check("rej_done1", 32'(bus.done), 32'h0);
    step();
    check("rej_done2", 32'(bus.done), 32'h1);
    chk_reg("rej_result_add", 32'h0C, 32'h9);
    chk_reg("rej_ctrl_opcode", 32'h08, 32'h3);
    step();
    check("rej_done3", 32'(bus.done), 32'h0);
    step();
    check("rej_done4", 32'(bus.done), 32'h0);
    wr(32'h14, 32'h2000_0000);
    check("err_clear", 32'(bus.err), 32'h0);
    chk_reg("rej_status", 32'h14, 32'h4000_0004);

    // MC on a reserved MEM_SEL is an error with no writeback
    wr(32'h10, 32'h3);
    wr(32'h08, 32'h19);
    step();
    step();
    check("mc_done", 32'(bus.done), 32'h1);
    check("mc_err", 32'(bus.err), 32'h1);
    chk_reg("mc_result_kept", 32'h0C, 32'h9);
    chk_reg("mc_status", 32'h14, 32'h6000_0005);

    // single-lane write
    wrs(32'h20, 32'hAABB_CCDD, 4'b0010);
    chk_reg("strb_reg8", 32'h20, 32'h0000_CC00);

    // MR copies mem[8] into RESULT
    wr(32'h10, 32'h8);
    wr(32'h08, 32'h18);
    step();
    step();
    check("mr_done", 32'(bus.done), 32'h1);
    chk_reg("mr_result", 32'h0C, 32'h0000_CC00);

    // opcode 10
    wr(32'h14, 32'h2000_0000);
    wr(32'h00, 32'h7);
    wr(32'h04, 32'h6);
    wr(32'h08, 32'h1A);
`ifdef OP_REG_BANK_MUL_EN
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (bus.done) seen = 1'b1;
    end
    check("mul_no_early_done", 32'(seen), 32'h0);
    step();
    check("mul_done", 32'(bus.done), 32'h1);
    check("mul_err", 32'(bus.err), 32'h0);
    chk_reg("mul_result", 32'h0C, 32'd42);
`else
    step();
    check("op10_done1", 32'(bus.done), 32'h0);
    step();
    check("op10_done", 32'(bus.done), 32'h1);
    check("op10_err", 32'(bus.err), 32'h1);
    chk_reg("op10_result_kept", 32'h0C, 32'h0000_CC00);
`endif

    // reset aborts an operation in flight
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h1);
    wr(32'h08, 32'h10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done0", 32'(bus.done), 32'h0);
    step();
    check("abort_done1", 32'(bus.done), 32'h0);
    step();
    check("abort_done2", 32'(bus.done), 32'h0);
    chk_reg("abort_result", 32'h0C, 32'h0);
    chk_reg("abort_status", 32'h14, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
